// File: rtl/event_fifo.sv
// Event FIFO between the event builder write side and the Hydra TX read side.
// Stores parity-less words and tracks occupancy, overflow drops and high-water mark.
module event_fifo #(
  parameter int WIDTH     = 64,
  parameter int FIFO_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-2:0]     data_in,
  input  logic                 write_fifo_n,
  input  logic                 read_fifo_n,
  input  logic                 clear_fifo,
  output logic [WIDTH-2:0]     data_out,
  output logic                 fifo_empty,
  output logic                 fifo_half,
  output logic                 fifo_full,
  output logic [FIFO_BITS:0]   fifo_counter,
  output logic                 fifo_overflow,
  output logic [7:0]           drop_count,
  output logic [FIFO_BITS:0]   high_water
);

  localparam int unsigned DEPTH = 2 ** FIFO_BITS;
  localparam logic [FIFO_BITS-1:0] PTR_ONE = {{(FIFO_BITS-1){1'b0}}, 1'b1};
  localparam logic [FIFO_BITS:0]   CNT_ONE = {{FIFO_BITS{1'b0}}, 1'b1};

  logic [WIDTH-2:0]     r_mem [DEPTH];
  logic [FIFO_BITS-1:0] r_wptr;
  logic [FIFO_BITS-1:0] r_rptr;

  logic                 w_pop_acc;
  logic                 w_push_acc;
  logic                 w_drop;
  logic [FIFO_BITS:0]   w_count_next;

  // A pop on empty is ignored, so a simultaneous push/pop at count 0 is push-only.
  assign w_pop_acc  = ~read_fifo_n & ~fifo_empty;
  assign w_push_acc = ~write_fifo_n & (~fifo_full | w_pop_acc);
  assign w_drop     = ~write_fifo_n & ~w_push_acc;

  always_comb begin
    w_count_next = fifo_counter;
    if (w_push_acc && !w_pop_acc)
      w_count_next = fifo_counter + CNT_ONE;
    else if (!w_push_acc && w_pop_acc)
      w_count_next = fifo_counter - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset_n && !clear_fifo && w_push_acc)
      r_mem[r_wptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      data_out      <= '0;
      fifo_counter  <= '0;
      fifo_empty    <= 1'b1;
      fifo_half     <= 1'b0;
      fifo_full     <= 1'b0;
      fifo_overflow <= 1'b0;
      drop_count    <= '0;
      high_water    <= '0;
    end else if (clear_fifo) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      fifo_counter  <= '0;
      fifo_empty    <= 1'b1;
      fifo_half     <= 1'b0;
      fifo_full     <= 1'b0;
      fifo_overflow <= 1'b0;
      drop_count    <= '0;
      high_water    <= '0;
    end else begin
      if (w_push_acc)
        r_wptr <= r_wptr + PTR_ONE;
      if (w_pop_acc) begin
        r_rptr   <= r_rptr + PTR_ONE;
        data_out <= r_mem[r_rptr];
      end
      // Count never exceeds DEPTH, so the MSB alone marks full and MSB|next marks half.
      fifo_counter <= w_count_next;
      fifo_empty   <= (w_count_next == '0);
      fifo_full    <= w_count_next[FIFO_BITS];
      fifo_half    <= w_count_next[FIFO_BITS] | w_count_next[FIFO_BITS-1];
      if (w_drop) begin
        fifo_overflow <= 1'b1;
        if (drop_count != '1)
          drop_count <= drop_count + 8'd1;
      end
      if (w_count_next > high_water)
        high_water <= w_count_next;
    end
  end

endmodule
